// File: rtl/gate_sweep_ctrl.sv
// Bring-up sequencer for 2-input gate cells: sweeps {A,B}, settles,
// samples Out against an expected truth table and reports mismatches.
module gate_sweep_ctrl #(
  parameter int         SETTLE_CYCLES = 2,
  parameter int         PASSES        = 2,
  parameter logic [3:0] EXPECT        = 4'b0111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       Out,
  output logic       A,
  output logic       B,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam logic [7:0] LAST_PASS = 8'(PASSES - 1);

  state_t     state;
  logic [1:0] idx;
  logic [7:0] pcnt;
  logic [3:0] scnt;
  logic       miss;

  // X or Z on Out must count as a failure, hence the case inequality
  assign miss = (Out !== EXPECT[idx]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      A         <= 1'b0;
      B         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 8'd0;
      fail_vec  <= 4'd0;
      idx       <= 2'd0;
      pcnt      <= 8'd0;
      scnt      <= 4'd0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          A    <= 1'b0;
          B    <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            idx       <= 2'd0;
            pcnt      <= 8'd0;
            err_count <= 8'd0;
            fail_vec  <= 4'd0;
            pass      <= 1'b0;
            scnt      <= SETTLE_LD;
            busy      <= 1'b1;
            state     <= SETTLE;
          end
        end
        SETTLE: begin
          scnt <= scnt - 4'd1;
          if (scnt == 4'd1) state <= SAMPLE;
        end
        SAMPLE: begin
          if (miss) begin
            if (err_count != 8'hff) err_count <= err_count + 8'd1;
            fail_vec[idx] <= 1'b1;
          end
          if (idx != 2'd3) begin
            idx    <= idx + 2'd1;
            {A, B} <= idx + 2'd1;
            scnt   <= SETTLE_LD;
            state  <= SETTLE;
          end else if (pcnt < LAST_PASS) begin
            idx    <= 2'd0;
            {A, B} <= 2'd0;
            pcnt   <= pcnt + 8'd1;
            scnt   <= SETTLE_LD;
            state  <= SETTLE;
          end else begin
            {A, B} <= 2'd0;
            state  <= DONE;
          end
        end
        DONE: begin
          // err_count already includes the final vector's update
          done  <= 1'b1;
          pass  <= (err_count == 8'd0);
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Testbench for gate_sweep_ctrl: table of gate models plus
// hand sequences for mid-run start, reset and back-to-back runs.
module tb_gate_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic [1:0] mode = 2'd0;
  bit         sel = 1'b0;

  logic       A0, B0, busy0, done0, pass0;
  logic [7:0] err0;
  logic [3:0] fv0;
  logic       A1, B1, busy1, done1, pass1;
  logic [7:0] err1;
  logic [3:0] fv1;
  logic       out0, out1;

  // gate model with registered inputs and registered output
  logic [1:0] ab0_r, ab1_r;
  logic       slow0, slow1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ab0_r <= 2'b00;
      ab1_r <= 2'b00;
      slow0 <= 1'b1;
      slow1 <= 1'b1;
    end else begin
      ab0_r <= {A0, B0};
      ab1_r <= {A1, B1};
      slow0 <= ~(ab0_r[1] & ab0_r[0]);
      slow1 <= ~(ab1_r[1] & ab1_r[0]);
    end
  end

  always_comb begin
    out0 = ~(A0 & B0);
    case (mode)
      2'd1: out0 = 1'b1;
      2'd2: out0 = A0 & B0;
      2'd3: out0 = slow0;
      default: out0 = ~(A0 & B0);
    endcase
  end
  assign out1 = slow1;

  gate_sweep_ctrl dut0 (
    .clk(clk), .rst(rst), .start(start0), .Out(out0),
    .A(A0), .B(B0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_vec(fv0)
  );

  gate_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .Out(out1),
    .A(A1), .B(B1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_vec(fv1)
  );

  logic       c_a, c_b, c_done, c_pass, c_busy;
  logic [7:0] c_err;
  logic [3:0] c_fv;
  assign c_a    = sel ? A1 : A0;
  assign c_b    = sel ? B1 : B0;
  assign c_done = sel ? done1 : done0;
  assign c_pass = sel ? pass1 : pass0;
  assign c_busy = sel ? busy1 : busy0;
  assign c_err  = sel ? err1 : err0;
  assign c_fv   = sel ? fv1 : fv0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // start pulse, then watch 40 cycles; k counts cycles from the accept edge
  task automatic run(input bit s, input bit poke, output int lat,
                     output int nd, output int aberr, output int bsy);
    logic [1:0] ev;
    sel = s;
    lat = -1;
    nd = 0;
    aberr = 0;
    bsy = 0;
    @(negedge clk);
    if (s) start1 = 1'b1;
    else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      ev = 2'((k / 3) % 4);
      if (k < 24 && !s && {c_a, c_b} !== ev) aberr++;
      if (k == 0) bsy = int'(c_busy);
      if (c_done) begin
        nd++;
        if (lat < 0) lat = k;
      end
      start0 = poke && (k == 4 || k == 9);
      @(negedge clk);
    end
    start0 = 1'b0;
  endtask

  typedef struct {
    logic [1:0] mode;
    bit         sel;
    logic [7:0] err;
    logic [3:0] fv;
    logic       pass;
    int         lat;
  } vec_t;

  vec_t tv[5];

  initial begin
    int lat, nd, aberr, bsy;
    int d1, d2, ndb;

    tv[0] = '{2'd0, 1'b0, 8'd0, 4'b0000, 1'b1, 25};
    tv[1] = '{2'd1, 1'b0, 8'd2, 4'b1000, 1'b0, 25};
    tv[2] = '{2'd2, 1'b0, 8'd8, 4'b1111, 1'b0, 25};
    tv[3] = '{2'd3, 1'b0, 8'd0, 4'b0000, 1'b1, 25};
    tv[4] = '{2'd0, 1'b1, 8'd3, 4'b1001, 1'b0, 17};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {A0, B0, busy0, done0, pass0, err0, fv0}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    foreach (tv[i]) begin
      mode = tv[i].mode;
      run(tv[i].sel, 1'b0, lat, nd, aberr, bsy);
      chk($sformatf("v%0d_latency", i), lat, tv[i].lat);
      chk($sformatf("v%0d_done_count", i), nd, 1);
      chk($sformatf("v%0d_err_count", i), c_err, tv[i].err);
      chk($sformatf("v%0d_fail_vec", i), c_fv, tv[i].fv);
      chk($sformatf("v%0d_pass", i), c_pass, tv[i].pass);
      chk($sformatf("v%0d_busy_start", i), bsy, 1);
      if (!tv[i].sel) chk($sformatf("v%0d_ab_seq", i), aberr, 0);
    end

    // start pulses mid-run must be ignored
    mode = 2'd0;
    run(1'b0, 1'b1, lat, nd, aberr, bsy);
    chk("poke_latency", lat, 25);
    chk("poke_done_count", nd, 1);
    chk("poke_err_count", err0, 0);
    chk("poke_pass", pass0, 1);

    // reset mid-run with a failing gate
    mode = 2'd2;
    sel = 1'b0;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {A0, B0, busy0, done0, pass0, err0, fv0}, 0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      if (done0 || busy0) nd++;
      @(negedge clk);
    end
    chk("midrst_no_done", nd, 0);
    mode = 2'd0;
    run(1'b0, 1'b0, lat, nd, aberr, bsy);
    chk("postrst_latency", lat, 25);
    chk("postrst_pass", pass0, 1);

    // start held high: back-to-back runs
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    d1 = -1;
    d2 = -1;
    ndb = 0;
    for (int k = 0; k < 60; k++) begin
      if (done0) begin
        ndb++;
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
      end
      @(negedge clk);
    end
    start0 = 1'b0;
    chk("b2b_first_done", d1, 25);
    chk("b2b_second_done", d2, 51);
    chk("b2b_done_count", ndb, 2);
    repeat (40) @(negedge clk);
    chk("b2b_final_pass", pass0, 1);
    chk("b2b_idle", busy0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
